// File: rtl/wb_pipe_pkg.sv
// Shared EX/WB pipeline types: control-bit layout, entry record and buffer occupancy states.
package wb_pipe_pkg;

  localparam int WB_CTRL_W = 7;
  localparam int WB_DATA_W = 32;
  localparam int WB_RD_W   = 6;

  localparam int WB_REGWRT   = 6;
  localparam int WB_BRANCH   = 5;
  localparam int WB_BTYPE    = 4;
  localparam int WB_JUMP     = 3;
  localparam int WB_MEMTOREG = 2;
  localparam int WB_NEG      = 1;
  localparam int WB_ZERO     = 0;

  typedef struct packed {
    logic [WB_CTRL_W-1:0] ctrl;
    logic [WB_DATA_W-1:0] memdata;
    logic [WB_DATA_W-1:0] aluresult;
    logic [WB_RD_W-1:0]   rd;
  } wb_entry_t;

  // Encoding equals occupancy so the state doubles as the count output.
  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ONE   = 2'd1,
    WB_FULL  = 2'd2
  } wb_occ_e;

endpackage

// File: rtl/wb_stage_buffer_if.sv
// EX->WB handshake bundle: upstream entry port plus write-back head port.
interface wb_stage_buffer_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 6,
  parameter int CTRL_W = 7
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_memdata;
  logic [DATA_W-1:0] in_aluresult;
  logic [RD_W-1:0]   in_rd;

  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_memdata;
  logic [DATA_W-1:0] out_aluresult;
  logic [RD_W-1:0]   out_rd;
  logic [1:0]        out_count;

  // Environment side: drives entries, consumes the head.
  modport master (
    output in_valid, in_ctrl, in_memdata, in_aluresult, in_rd, out_ready,
    input  in_ready, out_valid, out_ctrl, out_memdata, out_aluresult, out_rd, out_count
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_ctrl, in_memdata, in_aluresult, in_rd, out_ready,
    output in_ready, out_valid, out_ctrl, out_memdata, out_aluresult, out_rd, out_count
  );
endinterface

// File: rtl/wb_stage_slot.sv
// Single entry register: loads on 'load', cleared synchronously while rst_n is low.
module wb_stage_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] ent_d, ent_q;

  always_comb begin
    ent_d = ent_q;
    if (load) ent_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  assign q = ent_q;

endmodule

// File: rtl/wb_stage_buffer.sv
// EX/WB stage buffer: 2-entry head+skid, 1-cycle latency, in_ready registered (skid empty), flush injects a bubble.
// WB_BUF_HALFCYCLE_EN: outputs come from a negedge copy register, updating half a cycle after the posedge.
module wb_stage_buffer
  import wb_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 6,
  parameter int CTRL_W = 7
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  wb_stage_buffer_if.slave  bus
);

  localparam int ENTRY_W = CTRL_W + 2 * DATA_W + RD_W;
  localparam int OUT_W   = 1 + 2 + ENTRY_W;

  wb_occ_e            state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               accept, emit, head_vld;
  logic               h_load, s_load, h_from_s;
  logic [ENTRY_W-1:0] in_ent, h_ent, s_ent, h_nxt;
  logic [CTRL_W-1:0]  live_ctrl;
  logic [OUT_W-1:0]   live_vec, out_vec;

  assign in_ent   = {bus.in_ctrl, bus.in_memdata, bus.in_aluresult, bus.in_rd};
  assign head_vld = (state_q != WB_EMPTY);
  assign accept   = bus.in_valid & in_ready_q;
  assign emit     = head_vld & bus.out_ready;

  always_comb begin
    state_d  = state_q;
    h_load   = 1'b0;
    s_load   = 1'b0;
    h_from_s = 1'b0;
    if (flush) begin
      state_d = WB_EMPTY;
    end else begin
      case (state_q)
        WB_EMPTY: if (accept) begin
          state_d = WB_ONE;
          h_load  = 1'b1;
        end
        WB_ONE: begin
          if (accept && emit) begin
            h_load = 1'b1;
          end else if (accept) begin
            state_d = WB_FULL;
            s_load  = 1'b1;
          end else if (emit) begin
            state_d = WB_EMPTY;
          end
        end
        WB_FULL: if (emit) begin
          state_d  = WB_ONE;
          h_load   = 1'b1;
          h_from_s = 1'b1;
        end
        default: state_d = WB_EMPTY;
      endcase
    end
    in_ready_d = (state_d != WB_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= WB_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign h_nxt = h_from_s ? s_ent : in_ent;

  wb_stage_slot #(.W(ENTRY_W)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (h_load),
    .d     (h_nxt),
    .q     (h_ent)
  );

  wb_stage_slot #(.W(ENTRY_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (s_load),
    .d     (in_ent),
    .q     (s_ent)
  );

  // Control is gated so a stale head can never raise regwrt/branch/jump.
  assign live_ctrl = head_vld ? h_ent[ENTRY_W-1 -: CTRL_W] : '0;
  assign live_vec  = {head_vld, state_q, live_ctrl, h_ent[ENTRY_W-CTRL_W-1:0]};

`ifdef WB_BUF_HALFCYCLE_EN
  logic [OUT_W-1:0] copy_d, copy_q;

  always_comb begin
    copy_d = live_vec;
  end

  always_ff @(negedge clk) begin
    if (!rst_n) copy_q <= '0;
    else        copy_q <= copy_d;
  end

  assign out_vec = copy_q;
`else
  assign out_vec = live_vec;
`endif

  assign bus.in_ready = in_ready_q;
  assign {bus.out_valid, bus.out_count, bus.out_ctrl,
          bus.out_memdata, bus.out_aluresult, bus.out_rd} = out_vec;

endmodule

// File: tb/tb_wb_stage_buffer.sv
// Scoreboard bench for wb_stage_buffer: driver queues expected entries on acceptance, monitor pops on each emit.
module tb_wb_stage_buffer;
  import wb_pipe_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   cyc;
  int   chk_cnt;
  int   pass_cnt;

  wb_entry_t exp_q[$];
  int        lat_q[$];

  wb_stage_buffer_if bus ();

  wb_stage_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (chk=%0d)", chk_cnt);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One time unit before the next posedge: outputs settled in both build variants.
  task automatic pre();
    @(negedge clk);
    #4;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) post();
  endtask

  task automatic send(input logic [5:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                      input logic [6:0] ctrl, input bit keep, input int lat, output int waits);
    bit        ok;
    wb_entry_t e;
    bus.in_valid     = 1'b1;
    bus.in_rd        = rd;
    bus.in_aluresult = alu;
    bus.in_memdata   = mem;
    bus.in_ctrl      = ctrl;
    waits = 0;
    ok    = 1'b0;
    while (!ok && waits < 50) begin
      pre();
      if (bus.in_ready) ok = 1'b1;
      else waits++;
    end
    if (!ok) chk("send_accept_timeout", 64'd0, 64'd1);
    if (ok && keep) begin
      e.ctrl      = ctrl;
      e.memdata   = mem;
      e.aluresult = alu;
      e.rd        = rd;
      exp_q.push_back(e);
      lat_q.push_back(lat < 0 ? -1 : cyc + lat);
    end
    post();
  endtask

  // Monitor
  initial begin
    wb_entry_t e;
    int        lat;
    forever begin
      pre();
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_emit_rd", {58'd0, bus.out_rd}, 64'hFFFF);
        end else begin
          e   = exp_q.pop_front();
          lat = lat_q.pop_front();
          chk("emit_rd",        {58'd0, bus.out_rd},        {58'd0, e.rd});
          chk("emit_aluresult", {32'd0, bus.out_aluresult}, {32'd0, e.aluresult});
          chk("emit_memdata",   {32'd0, bus.out_memdata},   {32'd0, e.memdata});
          chk("emit_ctrl",      {57'd0, bus.out_ctrl},      {57'd0, e.ctrl});
          if (lat >= 0) chk("emit_latency", cyc, lat);
        end
      end else if (rst_n && !bus.out_valid) begin
        chk("bubble_ctrl", {57'd0, bus.out_ctrl}, 64'd0);
      end
    end
  end

  initial begin
    int w;
    chk_cnt  = 0;
    pass_cnt = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_ctrl      = 7'h7F;
    bus.in_rd        = 6'h3F;
    bus.in_aluresult = 32'hFFFF_FFFF;
    bus.in_memdata   = 32'hFFFF_FFFF;
    bus.out_ready    = 1'b1;

    // Reset held two edges with in_valid high
    repeat (2) post();
    pre();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_ctrl",  bus.out_ctrl, 7'h00);
    chk("rst_out_count", bus.out_count, 2'd0);
    chk("rst_in_ready",  bus.in_ready, 1'b1);
    chk("rst_out_rd",    bus.out_rd, 6'd0);
    chk("rst_out_alu",   bus.out_aluresult, 32'd0);
    post();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    idle(2);

    // Streaming rd=1..8, one-cycle latency, no stalls
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(6'(i), 32'h100 + i, 32'hA000 + i, 7'(32'h40 + i), 1'b1, 1, w);
      chk("stream_no_stall", w, 0);
    end
    idle(3);
    pre();
    chk("stream_drained_count", bus.out_count, 2'd0);
    post();

    // Backpressure: fill both slots, rd=5 held off, release
    bus.out_ready = 1'b0;
    send(6'd3, 32'h103, 32'hB003, 7'h43, 1'b1, -1, w);
    send(6'd4, 32'h104, 32'hB004, 7'h24, 1'b1, -1, w);
    bus.in_valid     = 1'b1;
    bus.in_rd        = 6'd5;
    bus.in_aluresult = 32'h105;
    pre();
    chk("bp_count_full", bus.out_count, 2'd2);
    chk("bp_in_ready",   bus.in_ready, 1'b0);
    post();
    pre();
    chk("bp_hold_in_ready", bus.in_ready, 1'b0);
    chk("bp_head_rd",       bus.out_rd, 6'd3);
    post();
    bus.out_ready = 1'b1;
    send(6'd5, 32'h105, 32'hB005, 7'h09, 1'b1, -1, w);
    chk("bp_release_wait", w, 1);
    idle(4);

    // Flush while FULL with rd=9 offered
    bus.out_ready = 1'b0;
    send(6'd7, 32'h107, 32'hC007, 7'h7F, 1'b0, -1, w);
    send(6'd8, 32'h108, 32'hC008, 7'h7F, 1'b0, -1, w);
    bus.in_valid     = 1'b1;
    bus.in_rd        = 6'd9;
    bus.in_ctrl      = 7'h7F;
    bus.in_aluresult = 32'h109;
    flush = 1'b1;
    post();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    pre();
    chk("flush_out_valid",   bus.out_valid, 1'b0);
    chk("flush_out_ctrl",    bus.out_ctrl, 7'h00);
    chk("flush_out_count",   bus.out_count, 2'd0);
    chk("flush_in_ready",    bus.in_ready, 1'b1);
    chk("flush_rd_retained", bus.out_rd, 6'd7);
    post();
    bus.out_ready = 1'b1;
    idle(4);

    // Flush in ONE with a concurrent accept: new entry discarded too
    bus.out_ready = 1'b0;
    send(6'd11, 32'h10B, 32'hD00B, 7'h40, 1'b0, -1, w);
    flush = 1'b1;
    send(6'd12, 32'h10C, 32'hD00C, 7'h40, 1'b0, -1, w);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    pre();
    chk("flush1_out_valid", bus.out_valid, 1'b0);
    chk("flush1_out_count", bus.out_count, 2'd0);
    post();
    bus.out_ready = 1'b1;
    idle(3);

    // Reset and flush in the same cycle with all-ones control
    bus.out_ready = 1'b0;
    send(6'd13, 32'h1234_5678, 32'h9ABC_DEF0, 7'h7F, 1'b0, -1, w);
    bus.in_valid = 1'b1;
    bus.in_ctrl  = 7'h7F;
    flush = 1'b1;
    rst_n = 1'b0;
    post();
    rst_n = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    pre();
    chk("rf_out_valid", bus.out_valid, 1'b0);
    chk("rf_out_ctrl",  bus.out_ctrl, 7'h00);
    chk("rf_out_count", bus.out_count, 2'd0);
    chk("rf_in_ready",  bus.in_ready, 1'b1);
    chk("rf_out_rd",    bus.out_rd, 6'd0);
    chk("rf_out_alu",   bus.out_aluresult, 32'd0);
    chk("rf_out_mem",   bus.out_memdata, 32'd0);
    post();

    // Output update timing relative to the accepting edge
    bus.out_ready = 1'b1;
    send(6'd20, 32'hDEAD_BEEF, 32'h0000_1234, 7'h41, 1'b1, 1, w);
`ifdef WB_BUF_HALFCYCLE_EN
    chk("half_before_negedge", bus.out_aluresult, 32'd0);
    @(negedge clk);
    #1;
    chk("half_after_negedge", bus.out_aluresult, 32'hDEAD_BEEF);
    post();
`else
    chk("direct_after_posedge", bus.out_aluresult, 32'hDEAD_BEEF);
`endif
    idle(4);

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/wb_stage_buffer.md
# wb_stage_buffer

Parametrised EX/WB pipeline stage buffer carrying write-back control bits and data between the execute and write-back stages. It replaces the fixed-width, always-advancing stage register with one that has a valid/ready handshake, a two-entry skid so upstream never stalls combinationally, synchronous flush with bubble injection, and optional half-cycle output update for write-first-half register files.

## Interface
- DATA_W, 32, width of memdata and aluresult fields
- RD_W, 6, destination register index width
- CTRL_W, 7, WB control vector width: {regwrt, branch, btype, jump, memtoreg, neg, zero}, bit 0 = zero
- clk  in  1  clock; single clock domain
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  discard all held entries this cycle
- in_valid  in  1  upstream entry present
- in_ready  out  1  buffer can accept; registered, equals "skid slot empty"
- in_ctrl  in  CTRL_W  WB control vector
- in_memdata  in  DATA_W  memory read data
- in_aluresult  in  DATA_W  ALU result
- in_rd  in  RD_W  destination register
- out_valid  out  1  head entry present
- out_ready  in  1  write-back consumes head
- out_ctrl  out  CTRL_W  head control; all-zero whenever out_valid=0
- out_memdata, out_aluresult  out  DATA_W  head data
- out_rd  out  RD_W  head destination
- out_count  out  2  occupancy 0..2

## Operation
- Two slots: head (H) and skid (S). accept = in_valid & in_ready; emit = out_valid & out_ready.
- States by occupancy: EMPTY(0), ONE(1), FULL(2).
- EMPTY: accept -> ONE, H<=in. out_ready ignored.
- ONE: accept&emit -> ONE, H<=in; accept&!emit -> FULL, S<=in; !accept&emit -> EMPTY; else hold.
- FULL: in_ready=0, no accept; emit -> ONE, H<=S; else hold.
- Order strictly FIFO; no entry duplicated or lost except on flush.
- flush (rst_n high): next state EMPTY regardless of accept/emit; concurrent input discarded; in_ready=1 next cycle. Data fields retain last values; out_ctrl forced zero via valid gating.
- Bubble rule: out_ctrl = out_valid ? H.ctrl : 0, so regwrt/branch/jump never assert from a stale slot.
- rst_n low: priority over flush; all valids 0, all data/rd/ctrl fields 0, out_count 0, in_ready 1 after the edge.
- No arithmetic; fields pass through unmodified, widths exact.

## Timing
- Latency: entry accepted at posedge k appears on outputs after posedge k (one cycle), given EMPTY or emit at k.
- Throughput: one entry per cycle when out_ready held high.
- in_ready has no combinational path from out_ready or in_valid.
- out_* depend only on registers (plus macro copy stage); no input-to-output combinational path.
- Reset mid-transfer: entries in H and S lost; no emit reported that cycle.

## Configuration
- WB_BUF_HALFCYCLE_EN defined: all out_* (incl. out_valid, out_count) driven from a copy register loaded on negedge clk from internal state; outputs change half a cycle after the posedge. Copy register cleared on negedge when rst_n low. Handshake decisions at posedge use internal state, which equals the copy by then.
- Not defined: out_* driven directly from posedge registers; no negedge logic.

## Structure
- Shared package wb_pipe_pkg: WB_CTRL_W=7, bit-index constants WB_REGWRT..WB_ZERO, packed typedef wb_entry_t {ctrl, memdata, aluresult, rd} at default widths.
- One sub-module: wb_stage_slot, a single entry register with load and synchronous clear, instantiated for H and S.

## Test plan
- Reset: rst_n=0 two cycles with in_valid=1 -> out_valid=0, out_ctrl=0, out_count=0, in_ready=1.
- Streaming: out_ready=1, entries rd=1..8, aluresult=0x100+rd each cycle -> same sequence out, one-cycle latency, in_ready stays 1.
- Backpressure: out_ready=0, push rd=3, rd=4 -> out_count=2, in_ready=0, rd=5 held off; release out_ready -> rd 3,4,5 in order.
- Flush in FULL with in_valid=1 (rd=9) -> next cycle out_valid=0, out_ctrl=0, count=0; rd=9 never emitted.
- Reset vs flush same cycle with ctrl=7'h7F -> reset values, all zero.
- With WB_BUF_HALFCYCLE_EN: accept aluresult=0xDEADBEEF at posedge -> out_aluresult changes at following negedge, not at posedge.
